// File: rtl/mmio_shadow_bank.sv
// mmio_shadow_bank: MMIO block between the CPU data port and the display/input
// peripherals. Snoops CPU stores into X/Y coordinate windows, keeps a shadow
// bank of points, latches button edges, holds a sticky game-done flag, and
// muxes these registers into the CPU read path ahead of RAM.
// Optional feature macro: MMIO_DBUF_EN -- when defined, window stores land in
// a back bank that is copied to the front bank on a requested frame boundary;
// when undefined, window stores write the front bank directly.
module mmio_shadow_bank #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int NPTS      = 100,
  parameter int X_BASE    = 300,
  parameter int Y_BASE    = 400,
  parameter int BTN_ADDR  = 0,
  parameter int DONE_ADDR = 1,
  parameter int CTRL_ADDR = 2,
  parameter int NBTN      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wren,
  input  logic [ADDR_W-1:0]      address_dmem,
  input  logic [DATA_W-1:0]      data,
  input  logic [DATA_W-1:0]      ram_q,
  output logic [DATA_W-1:0]      q_dmem,
  input  logic [NBTN-1:0]        btn_in,
  input  logic                   frame_sync,
  output logic [NPTS*DATA_W-1:0] x_values,
  output logic [NPTS*DATA_W-1:0] y_values,
  output logic                   game_done,
  output logic                   swap_done
);

  localparam int IDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;

  localparam logic [ADDR_W-1:0] XLo   = ADDR_W'(X_BASE);
  localparam logic [ADDR_W-1:0] XHi   = ADDR_W'(X_BASE + NPTS);
  localparam logic [ADDR_W-1:0] YLo   = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] YHi   = ADDR_W'(Y_BASE + NPTS);
  localparam logic [ADDR_W-1:0] BtnA  = ADDR_W'(BTN_ADDR);
  localparam logic [ADDR_W-1:0] DoneA = ADDR_W'(DONE_ADDR);
  localparam logic [ADDR_W-1:0] CtrlA = ADDR_W'(CTRL_ADDR);

  logic              xWrite;
  logic              yWrite;
  logic [IDX_W-1:0]  xIdx;
  logic [IDX_W-1:0]  yIdx;
  logic              pending;

  logic [DATA_W-1:0] xFront_q [NPTS];
  logic [DATA_W-1:0] yFront_q [NPTS];

  logic [NBTN-1:0]   btnSync1_q;
  logic [NBTN-1:0]   btnSync2_q;
  logic [NBTN-1:0]   btnPrev_q;
  logic [NBTN-1:0]   btnLat_q;
  logic [NBTN-1:0]   btnLat_d;
  logic              gameDone_q;

  assign xWrite = wren && (address_dmem >= XLo) && (address_dmem < XHi);
  assign yWrite = wren && (address_dmem >= YLo) && (address_dmem < YHi);
  assign xIdx   = IDX_W'(address_dmem - XLo);
  assign yIdx   = IDX_W'(address_dmem - YLo);

`ifdef MMIO_DBUF_EN
  logic [DATA_W-1:0] xBack_q [NPTS];
  logic [DATA_W-1:0] yBack_q [NPTS];
  logic              pending_q;
  logic              swapDone_q;
  logic              swapNow;
  logic              swapReq;

  assign swapNow = frame_sync && pending_q;
  assign swapReq = wren && (address_dmem == CtrlA) && data[0];

  // Back banks take every window store; front banks copy the pre-store back
  // contents on a swap edge, so a store in the swap cycle stays in the back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPTS; i++) begin
        xBack_q[i]  <= '0;
        yBack_q[i]  <= '0;
        xFront_q[i] <= '0;
        yFront_q[i] <= '0;
      end
    end else begin
      if (swapNow) begin
        for (int i = 0; i < NPTS; i++) begin
          xFront_q[i] <= xBack_q[i];
          yFront_q[i] <= yBack_q[i];
        end
      end
      if (xWrite) xBack_q[xIdx] <= data;
      if (yWrite) yBack_q[yIdx] <= data;
    end
  end

  // Swap request/acknowledge: a request made in a swap cycle is dropped, and
  // a request on a frame_sync with nothing pending waits for the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q  <= 1'b0;
      swapDone_q <= 1'b0;
    end else begin
      swapDone_q <= swapNow;
      if (swapNow) pending_q <= 1'b0;
      else if (swapReq) pending_q <= 1'b1;
    end
  end

  assign pending   = pending_q;
  assign swap_done = swapDone_q;
`else
  logic unusedFrameSync;
  assign unusedFrameSync = frame_sync;

  // Single-buffered: window stores write the visible bank directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPTS; i++) begin
        xFront_q[i] <= '0;
        yFront_q[i] <= '0;
      end
    end else begin
      if (xWrite) xFront_q[xIdx] <= data;
      if (yWrite) yFront_q[yIdx] <= data;
    end
  end

  assign pending   = 1'b0;
  assign swap_done = 1'b0;
`endif

  // Flatten the front banks onto the display ports.
  for (genvar g = 0; g < NPTS; g++) begin : gFlat
    assign x_values[g*DATA_W +: DATA_W] = xFront_q[g];
    assign y_values[g*DATA_W +: DATA_W] = yFront_q[g];
  end

  // Button latch: new rising edges set bits, a store writes 1s to clear,
  // and a set beats a clear on the same bit.
  always_comb begin
    btnLat_d = btnLat_q;
    if (wren && (address_dmem == BtnA)) btnLat_d = btnLat_d & ~data[NBTN-1:0];
    btnLat_d = btnLat_d | (btnSync2_q & ~btnPrev_q);
  end

  // Two-stage synchroniser, edge-detect history, button latch and done flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btnSync1_q <= '0;
      btnSync2_q <= '0;
      btnPrev_q  <= '0;
      btnLat_q   <= '0;
      gameDone_q <= 1'b0;
    end else begin
      btnSync1_q <= btn_in;
      btnSync2_q <= btnSync1_q;
      btnPrev_q  <= btnSync2_q;
      btnLat_q   <= btnLat_d;
      if (wren && (address_dmem == DoneA) && (data != '0)) gameDone_q <= 1'b1;
    end
  end

  assign game_done = gameDone_q;

  // CPU read mux: MMIO registers override RAM, everything else is RAM data.
  always_comb begin
    q_dmem = ram_q;
    if (address_dmem == BtnA)       q_dmem = DATA_W'(btnLat_q);
    else if (address_dmem == DoneA) q_dmem = DATA_W'(gameDone_q);
    else if (address_dmem == CtrlA) q_dmem = DATA_W'(pending);
  end

endmodule
